// File: rtl/dma_row_sequencer.sv
// dma_row_sequencer: takes whole decompressed rows over valid/ready and writes
// them into block RAM one BLOCK_SIZE-bit word per cycle, lowest word first, at
// consecutive addresses from a programmed base. It waits while another master
// holds the RAM port and pulses done once the programmed row count is written.
module dma_row_sequencer #(
   parameter int ROW_SIZE   = 16,
   parameter int BLOCK_SIZE = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  num_rows,
   input  logic                  row_valid,
   input  logic [ROW_SIZE-1:0]   row_data,
   output logic                  row_ready,
   input  logic                  ram_busy,
   output logic                  ram_enable,
   output logic                  ram_write,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [BLOCK_SIZE-1:0] ram_wdata,
   output logic                  busy,
   output logic                  done
);

   localparam int WORDS = ROW_SIZE / BLOCK_SIZE;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_ROW,
      S_WRITE,
      S_FINISH
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [ROW_SIZE-1:0]     row_buf_q;
   logic [IDX_W-1:0]        idx_q;
   logic [CNT_WIDTH-1:0]    rows_left_q;
   logic [ADDR_WIDTH-1:0]   addr_q;

   logic                    load_cfg;
   logic                    load_row;
   logic                    write_fire;
   logic                    last_word;

   // Word idx of the buffered row; word 0 is the least significant slice.
   function automatic logic [BLOCK_SIZE-1:0] word_sel(input logic [ROW_SIZE-1:0] row,
                                                      input logic [IDX_W-1:0]    idx);
      return row[32'(idx) * BLOCK_SIZE +: BLOCK_SIZE];
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and all outputs; RAM address/data stay 0 unless a write fires.
   always_comb begin
      state_d     = state_q;
      row_ready   = 1'b0;
      ram_enable  = 1'b0;
      ram_write   = 1'b0;
      ram_address = '0;
      ram_wdata   = '0;
      busy        = (state_q != S_IDLE);
      done        = 1'b0;
      load_cfg    = 1'b0;
      load_row    = 1'b0;
      write_fire  = 1'b0;
      last_word   = (idx_q == LAST_IDX);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               load_cfg = 1'b1;
               state_d  = (num_rows == '0) ? S_FINISH : S_WAIT_ROW;
            end
         end

         S_WAIT_ROW: begin
            row_ready = 1'b1;
            if (row_valid) begin
               load_row = 1'b1;
               state_d  = S_WRITE;
            end
         end

         S_WRITE: begin
            // Another master owns the port: hold everything, drive nothing.
            if (!ram_busy) begin
               ram_enable  = 1'b1;
               ram_write   = 1'b1;
               ram_address = addr_q;
               ram_wdata   = word_sel(row_buf_q, idx_q);
               write_fire  = 1'b1;
               if (last_word) begin
                  state_d = (rows_left_q == CNT_WIDTH'(1)) ? S_FINISH : S_WAIT_ROW;
               end
            end
         end

         S_FINISH: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Row buffer, word index, remaining-row count and running address.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_buf_q   <= '0;
         idx_q       <= '0;
         rows_left_q <= '0;
         addr_q      <= '0;
      end else begin
         if (load_cfg) begin
            addr_q      <= base_addr;
            rows_left_q <= num_rows;
         end
         if (load_row) begin
            row_buf_q <= row_data;
            idx_q     <= '0;
         end
         if (write_fire) begin
            // Address is free-running modulo 2^ADDR_WIDTH, so a wrap is silent.
            addr_q <= addr_q + ADDR_WIDTH'(1);
            if (last_word) begin
               idx_q       <= '0;
               rows_left_q <= rows_left_q - CNT_WIDTH'(1);
            end else begin
               idx_q <= idx_q + IDX_W'(1);
            end
         end
      end
   end

endmodule
